// File: rtl/mem_arbiter_if.sv
// Bundle between the I/D caches, the arbiter and the single-ported RAM.
// The slave modport is the arbiter's view; the master modport is the caches+RAM side.
interface mem_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        iwait;
    logic        dwait;
    logic [31:0] iload;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        err;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, err
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-ported RAM arbiter between instruction refills and data accesses of one core:
// data-first with a starvation cap, per-access watchdog, sticky error flag.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic         CLK,
    input  logic         RST,
    mem_arbiter_if.slave bus
);
    localparam int          SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [7:0]  TMAX       = 8'(TIMEOUT);
    localparam logic [1:0]  RS_ACCESS  = 2'd2;
    localparam logic [1:0]  RS_ERROR   = 2'd3;
    localparam logic [31:0] BAD_WORD   = 32'hBAD1BAD1;

    typedef enum logic [1:0] {IDLE = 2'd0, DGNT = 2'd1, IGNT = 2'd2} state_t;

    state_t        r_state, w_state_next;
    logic [SW-1:0] r_starve, w_starve_next;
    logic [7:0]    r_tcnt, w_tcnt_next;
    logic          r_err, w_err_next;
    logic [31:0]   r_iload, w_iload_next;
    logic [31:0]   r_dload, w_dload_next;

    logic          w_iwait, w_dwait, w_ramREN, w_ramWEN;
    logic [31:0]   w_ramaddr, w_ramstore;
    logic          w_fault, w_done;
    logic [31:0]   w_word;
    logic [SW-1:0] w_starve_inc;

    // A grant finishes on ACCESS, on ERROR, or when the watchdog expires.
    assign w_fault = (bus.ramstate == RS_ERROR) ||
                     ((bus.ramstate != RS_ACCESS) && (r_tcnt == TMAX));
    assign w_done  = (bus.ramstate == RS_ACCESS) || w_fault;
    assign w_word  = (bus.ramstate == RS_ACCESS) ? bus.ramload : BAD_WORD;
    assign w_starve_inc = (r_starve == STARVE_MAX) ? r_starve : r_starve + 1'b1;

    always_comb begin
        w_state_next  = r_state;
        w_starve_next = r_starve;
        w_tcnt_next   = 8'd0;
        w_err_next    = r_err;
        w_iload_next  = r_iload;
        w_dload_next  = r_dload;
        w_iwait       = 1'b1;
        w_dwait       = 1'b1;
        w_ramREN      = 1'b0;
        w_ramWEN      = 1'b0;
        w_ramaddr     = 32'd0;
        w_ramstore    = 32'd0;

        case (r_state)
            IDLE: begin
                if ((bus.dREN || bus.dWEN) && !(bus.iREN && (r_starve == STARVE_MAX)))
                    w_state_next = DGNT;
                else if (bus.iREN)
                    w_state_next = IGNT;
            end
            DGNT: begin
                if (!(bus.dREN || bus.dWEN)) begin
                    w_state_next = IDLE;
                end else begin
                    w_ramaddr  = bus.daddr;
                    w_ramWEN   = bus.dWEN;
                    w_ramREN   = bus.dREN && !bus.dWEN;
                    w_ramstore = bus.dstore;
                    if (w_done) begin
                        w_dwait       = 1'b0;
                        w_dload_next  = w_word;
                        w_state_next  = IDLE;
                        w_err_next    = r_err || w_fault;
                        w_starve_next = bus.iREN ? w_starve_inc : '0;
                    end else begin
                        w_tcnt_next = r_tcnt + 8'd1;
                    end
                end
            end
            IGNT: begin
                if (!bus.iREN) begin
                    w_state_next = IDLE;
                end else begin
                    w_ramaddr = bus.iaddr;
                    w_ramREN  = 1'b1;
                    if (w_done) begin
                        w_iwait       = 1'b0;
                        w_iload_next  = w_word;
                        w_state_next  = IDLE;
                        w_err_next    = r_err || w_fault;
                        w_starve_next = '0;
                    end else begin
                        w_tcnt_next = r_tcnt + 8'd1;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= IDLE;
            r_starve <= '0;
            r_tcnt   <= 8'd0;
            r_err    <= 1'b0;
            r_iload  <= 32'd0;
            r_dload  <= 32'd0;
        end else begin
            r_state  <= w_state_next;
            r_starve <= w_starve_next;
            r_tcnt   <= w_tcnt_next;
            r_err    <= w_err_next;
            r_iload  <= w_iload_next;
            r_dload  <= w_dload_next;
        end
    end

    // The completing cycle already shows the new word; it is held from the register after.
    assign bus.iload    = w_iload_next;
    assign bus.dload    = w_dload_next;
    assign bus.iwait    = w_iwait;
    assign bus.dwait    = w_dwait;
    assign bus.ramREN   = w_ramREN;
    assign bus.ramWEN   = w_ramWEN;
    assign bus.ramaddr  = w_ramaddr;
    assign bus.ramstore = w_ramstore;
    assign bus.err      = r_err;
endmodule
